// File: rtl/system_top_pkg.sv
// Shared definitions for the GPIO/UART I/O controller: command opcodes and
// the state encoding used by both UART state machines.
package system_top_pkg;

  localparam logic [7:0] CMD_WR_DIR  = 8'h01;
  localparam logic [7:0] CMD_WR_OUT  = 8'h02;
  localparam logic [7:0] CMD_RD_PINS = 8'h03;
  localparam logic [7:0] CMD_RD_DIR  = 8'h04;
  localparam logic [7:0] CMD_RD_OUT  = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

endpackage

// File: rtl/system_top_if.sv
// Byte-level link between the command logic and the UART.
// rx_valid pulses for one cycle with rx_data; tx_start is honoured only
// while tx_busy is low, and tx_busy rises on the following cycle.
interface system_top_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (input rx_data, rx_valid, tx_busy, output tx_data, tx_start);
  modport slave  (output rx_data, rx_valid, tx_busy, input tx_data, tx_start);
endinterface

// File: rtl/system_uart.sv
// 8N1 UART, LSB first: receiver with mid-bit sampling and transmitter, both
// timed by DIV clock cycles per bit.
module system_uart
  import system_top_pkg::*;
#(
  parameter int DIV = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_rxd,
  output logic         o_txd,
  system_top_if.slave  bus
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic          r_rx_meta, r_rx_sync;
  uart_state_t   r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_meta  <= i_rxd;
      r_rx_sync  <= r_rx_meta;
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        ST_IDLE: if (!r_rx_sync) begin
          r_rx_state <= ST_START;
          r_rx_cnt   <= '0;
        end
        ST_START: if (r_rx_cnt == HALF) begin
          // A line that is high again at mid start bit was a glitch.
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_sync ? ST_IDLE : ST_DATA;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        ST_DATA: if (r_rx_cnt == FULL) begin
          r_rx_cnt <= '0;
          r_rx_sh  <= {r_rx_sync, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 1'b1;
          if (r_rx_bit == 3'd7) r_rx_state <= ST_STOP;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        ST_STOP: if (r_rx_cnt == FULL) begin
          r_rx_cnt   <= '0;
          r_rx_state <= ST_IDLE;
          if (r_rx_sync) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_rx_sh;
          end
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  uart_state_t   r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_sh;
  logic          r_txd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
          if (bus.tx_start) begin
            r_tx_sh    <= bus.tx_data;
            r_tx_cnt   <= '0;
            r_txd      <= 1'b0;
            r_tx_state <= ST_START;
          end
        end
        ST_START: if (r_tx_cnt == FULL) begin
          r_tx_cnt   <= '0;
          r_tx_bit   <= '0;
          r_txd      <= r_tx_sh[0];
          r_tx_state <= ST_DATA;
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        ST_DATA: if (r_tx_cnt == FULL) begin
          r_tx_cnt <= '0;
          if (r_tx_bit == 3'd7) begin
            r_txd      <= 1'b1;
            r_tx_state <= ST_STOP;
          end else begin
            r_tx_bit <= r_tx_bit + 1'b1;
            r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
            r_txd    <= r_tx_sh[1];
          end
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        ST_STOP: if (r_tx_cnt == FULL) begin
          r_tx_cnt   <= '0;
          r_tx_state <= ST_IDLE;
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        default: r_tx_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.tx_busy  = (r_tx_state != ST_IDLE);
  assign o_txd        = r_txd;

endmodule

// File: rtl/system_top.sv
// Instrument-board I/O controller: UART command port driving an 8-bit GPIO
// bank, with autonomous reporting of input-pin changes and a status LED.
module system_top
  import system_top_pkg::*;
#(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 115200
) (
  input  logic       clk,
  input  logic       rst,
  output logic       led,
  input  logic       uart_rxd,
  output logic       uart_txd,
  inout  wire  [7:0] gpio_io
);

  // Clocks per bit; the receiver's mid-bit sampling needs at least 4.
  localparam int DIV = clk_freq / uart_baud_rate;

  system_top_if u_bus ();

  system_uart #(.DIV(DIV)) u_uart (
    .clk   (clk),
    .rst   (rst),
    .i_rxd (uart_rxd),
    .o_txd (uart_txd),
    .bus   (u_bus)
  );

  logic [7:0] r_dir, r_out, r_oe, r_do;
  logic [7:0] r_pin_meta, r_pins, r_watch;
  logic       r_evt, r_resp_pending, r_have_op, r_op_dir, r_led;
  logic [7:0] r_resp_data;
  logic [7:0] w_watch, w_rd_val;
  logic       w_take_resp, w_take_evt;

  for (genvar i = 0; i < 8; i++) begin : g_pad
    assign gpio_io[i] = r_oe[i] ? r_do[i] : 1'bz;
  end

  // Read responses win the transmitter over change reports.
  always_comb begin
    w_watch     = r_pins & ~r_dir;
    w_take_resp = !u_bus.tx_busy && r_resp_pending;
    w_take_evt  = !u_bus.tx_busy && !r_resp_pending && r_evt;
    case (u_bus.rx_data)
      CMD_RD_PINS: w_rd_val = r_pins;
      CMD_RD_DIR:  w_rd_val = r_dir;
      default:     w_rd_val = r_out;
    endcase
  end

  assign u_bus.tx_start = w_take_resp | w_take_evt;
  assign u_bus.tx_data  = r_resp_pending ? r_resp_data : r_pins;
  assign led            = r_led;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pin_meta <= '0;
      r_pins     <= '0;
      r_watch    <= '0;
      r_evt      <= 1'b0;
    end else begin
      r_pin_meta <= gpio_io;
      r_pins     <= r_pin_meta;
      r_watch    <= w_watch;
      // A change arriving as the previous report is taken still wins.
      if (w_watch != r_watch) r_evt <= 1'b1;
      else if (w_take_evt)    r_evt <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir          <= '0;
      r_out          <= '0;
      r_oe           <= '0;
      r_do           <= '0;
      r_resp_pending <= 1'b0;
      r_resp_data    <= '0;
      r_have_op      <= 1'b0;
      r_op_dir       <= 1'b0;
      r_led          <= 1'b0;
    end else begin
      r_oe <= r_dir;
      r_do <= r_out;
      if (w_take_resp) r_resp_pending <= 1'b0;
      if (u_bus.rx_valid) begin
        if (r_have_op) begin
          r_have_op <= 1'b0;
          r_led     <= ~r_led;
          if (r_op_dir) r_dir <= u_bus.rx_data;
          else          r_out <= u_bus.rx_data;
        end else begin
          case (u_bus.rx_data)
            CMD_WR_DIR, CMD_WR_OUT: begin
              r_have_op <= 1'b1;
              r_op_dir  <= (u_bus.rx_data == CMD_WR_DIR);
            end
            CMD_RD_PINS, CMD_RD_DIR, CMD_RD_OUT: begin
              r_led <= ~r_led;
              if (!r_resp_pending || w_take_resp) begin
                r_resp_pending <= 1'b1;
                r_resp_data    <= w_rd_val;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_system_top.sv
// Directed bench for system_top at DIV = 8: host commands over the serial
// line, GPIO drive/read-back, change reports, framing errors and resets.
module tb_system_top;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  wire        uart_txd;
  wire        led;
  wire  [7:0] gpio_io;
  logic [7:0] tb_en = 8'hFF;
  logic [7:0] tb_val = 8'h00;

  for (genvar i = 0; i < 8; i++) begin : g_tb_pad
    assign gpio_io[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  system_top #(.clk_freq(10000000), .uart_baud_rate(1152000)) dut (
    .clk      (clk),
    .rst      (rst),
    .led      (led),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .gpio_io  (gpio_io)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: observed time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  int         mon_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serial line monitor: decodes frames on uart_txd, dropping any cut by reset.
  logic [7:0] mon_b;
  logic       mon_ab;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && uart_txd === 1'b0) begin
        mon_ab = 1'b0;
        mon_b  = '0;
        for (int k = 0; k < DIV / 2; k++) begin @(negedge clk); mon_ab |= rst; end
        for (int b = 0; b < 8; b++) begin
          for (int k = 0; k < DIV; k++) begin @(negedge clk); mon_ab |= rst; end
          mon_b[b] = uart_txd;
        end
        for (int k = 0; k < DIV; k++) begin @(negedge clk); mon_ab |= rst; end
        if (!mon_ab) begin
          if (uart_txd === 1'b1) begin
            got_q.push_back(mon_b);
            got_cyc_q.push_back(cyc);
          end else mon_err++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rxd = 1'b0;
    step(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      step(DIV);
    end
    uart_rxd = stop_bit;
    step(DIV);
    uart_rxd = 1'b1;
  endtask

  task automatic check_frames(input string tag, input int budget, input int settle);
    int waited = 0;
    while (got_q.size() < exp_q.size() && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    step(settle);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  int t0, w, lat;
  initial begin
    step(5);
    rst = 1'b0;
    step(1000);
    chk("idle_txd", uart_txd, 1);
    chk("idle_led", led, 0);
    chk("idle_gpio", gpio_io, 8'h00);
    chk("idle_frames", got_q.size(), 0);

    // Reset values of dir and out read back over the serial line.
    uart_send(8'h04, 1'b1);
    uart_send(8'h05, 1'b1);
    exp_q = '{8'h00, 8'h00};
    check_frames("rd_reset", 400, 20);
    chk("rd_reset_led", led, 0);

    uart_send(8'h01, 1'b1);
    uart_send(8'hF0, 1'b1);
    step(12);
    chk("wr_dir_led", led, 1);
    tb_en = 8'h0F;
    uart_send(8'h02, 1'b1);
    uart_send(8'hA5, 1'b1);
    step(12);
    chk("wr_out_led", led, 0);
    chk("wr_gpio", gpio_io, 8'hA0);
    check_frames("wr_no_evt", 0, 100);

    // Single input change -> one report of the full pin value.
    tb_val = 8'h0A;
    t0 = cyc;
    w = 0;
    while (got_cyc_q.size() == 0 && w < 200) begin @(negedge clk); w++; end
    lat = (got_cyc_q.size() > 0) ? got_cyc_q[0] - t0 : 9999;
    chk("evt_latency_ok", lat <= 13 + 10 * DIV, 1);
    exp_q = '{8'hAA};
    check_frames("evt_one", 200, 200);

    tb_val = 8'h00;
    step(300);
    tb_val = 8'h0A;
    step(300);
    exp_q = '{8'hA0, 8'hAA};
    check_frames("evt_toggle", 100, 50);

    // Changes during a report coalesce into one follow-up with the latest pins.
    tb_val = 8'h00;
    step(20);
    tb_val = 8'h05;
    step(20);
    tb_val = 8'h03;
    exp_q = '{8'hA0, 8'hA3};
    check_frames("evt_coalesce", 300, 200);

    uart_send(8'h03, 1'b1);
    uart_send(8'h04, 1'b1);
    uart_send(8'h05, 1'b1);
    exp_q = '{8'hA3, 8'hF0, 8'hA5};
    check_frames("rd_regs", 400, 20);
    chk("rd_regs_led", led, 1);

    // Framing error on what would be a write-dir opcode, then an unknown opcode.
    uart_send(8'h01, 1'b0);
    step(3 * DIV);
    uart_send(8'h7E, 1'b1);
    step(12);
    chk("bad_led", led, 1);
    check_frames("bad_no_resp", 0, 100);
    uart_send(8'h04, 1'b1);
    uart_send(8'h05, 1'b1);
    exp_q = '{8'hF0, 8'hA5};
    check_frames("bad_regs", 400, 20);
    chk("bad_regs_led", led, 1);

    // Reset while a response is being transmitted.
    uart_send(8'h04, 1'b1);
    w = 0;
    while (uart_txd !== 1'b0 && w < 200) begin @(negedge clk); w++; end
    chk("rst_tx_started", uart_txd, 0);
    step(3 * DIV);
    rst = 1'b1;
    tb_en = 8'hFF;
    tb_val = 8'h00;
    step(1);
    chk("rst_txd", uart_txd, 1);
    step(2);
    rst = 1'b0;
    step(3);
    chk("rst_led", led, 0);
    chk("rst_gpio", gpio_io, 8'h00);

    // Half-received write command is forgotten across reset.
    uart_send(8'h01, 1'b1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(5);
    uart_send(8'h05, 1'b1);
    exp_q = '{8'h00};
    check_frames("rst_half_cmd", 200, 50);
    chk("rst_half_led", led, 1);

    chk("mon_stop_errs", mon_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
